out_channel_checker: RTL

Receives the word stream a test program emits on its out channel, buffers it, and compares each word in order against an expected sequence loaded beforehand. It drives `finished`/`success` from the observed stream, replacing per-test hard-coded `outMem` checks. It sits between the program-executing core (producer) and the board-level pass/fail pins.

---
 rtl/out_channel_pkg.sv | 12 +
 rtl/out_channel_fifo.sv | 39 +++
 rtl/out_channel_checker.sv | 125 ++++++++++++
 3 files changed

// File: rtl/out_channel_pkg.sv
// out_channel_pkg: shared state encoding, word width default and index-width helper for the out-channel checker
package out_channel_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  localparam int DefaultWordWidth = 12;
  // Bits needed to count 0..n-1; never below 1 so NOut=0 still yields a real port
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/out_channel_fifo.sv
// out_channel_fifo: synchronous FIFO with wrap-bit pointers, push and pop allowed in the same cycle
module out_channel_fifo #(
  parameter int Width = 12,
  parameter int Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(Depth);
  logic [Width-1:0] mem [Depth];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // pointer update; clear empties the buffer without touching storage
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // storage write
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/out_channel_checker.sv
// out_channel_checker: buffers the program's out-channel words and compares them in order against a preloaded expected sequence; OUT_CHANNEL_TIMEOUT_EN enables the idle timeout
module out_channel_checker
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultWordWidth,
  parameter int NOut = 2,
  parameter int FifoDepth = 4,
  parameter int TimeoutCycles = 64,
  localparam int IW = clog2(NOut + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          expWrite,
  input  logic [IW-1:0]                 expIndex,
  input  logic [MemoryElementWidth-1:0] expData,
  input  logic                          start,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          outReady,
  output logic                          finished,
  output logic                          success,
  output logic                          timedOut,
  output logic [IW-1:0]                 failIndex,
  output logic [MemoryElementWidth-1:0] failData
);
  localparam logic [IW-1:0] NOUT_I = IW'(NOut);
  localparam logic [IW-1:0] LAST_I = IW'(NOut - 1);
  state_t state, next_state;
  logic [MemoryElementWidth-1:0] exp_mem [2**IW];
  logic [MemoryElementWidth-1:0] head;
  logic [IW-1:0] rcv_cnt, cmp_cnt;
  logic fifo_full, fifo_empty, fifo_clear, fail_entry;
  logic go, xfer, pop, mismatch, last_match, surplus, timeout;
  assign fail_entry = next_state == FAIL && state != FAIL;
  assign fifo_clear = go || next_state == FAIL;
  out_channel_fifo #(
    .Width(MemoryElementWidth),
    .Depth(FifoDepth)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .clear(fifo_clear),
    .push(state == RUN && xfer),
    .pop(pop),
    .din(outData),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  // expected memory loads only while idle and survives reset
  always_ff @(posedge clock) begin
    if (state == IDLE && expWrite && expIndex < NOUT_I) exp_mem[expIndex] <= expData;
  end
  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else state <= next_state;
  end
  // transfer, compare and surplus events; the oldest failure wins
  always_comb begin
    go = start && state != RUN;
    xfer = outValid && outReady;
    pop = state == RUN && !fifo_empty;
    mismatch = pop && head != exp_mem[cmp_cnt];
    last_match = pop && !mismatch && cmp_cnt == LAST_I;
    surplus = xfer && (state == PASS || rcv_cnt == NOUT_I);
  end
  // next state; start re-runs from PASS or FAIL, NOut=0 passes straight away
  always_comb begin
    next_state = state;
    if (go) next_state = (NOut == 0) ? PASS : RUN;
    else if (state == RUN) next_state = (mismatch || surplus || timeout) ? FAIL : last_match ? PASS : RUN;
    else if (state == PASS && surplus) next_state = FAIL;
  end
  // ready decode: back-pressure only while running, always open in PASS to catch extras
  always_comb begin
    outReady = (state == RUN) ? !fifo_full : (state == PASS);
  end
  // registered verdict, counters and first-failure record
  always_ff @(posedge clock) begin
    if (!reset) begin
      finished <= 1'b0;
      success <= 1'b0;
      rcv_cnt <= '0;
      cmp_cnt <= '0;
      failIndex <= '0;
      failData <= '0;
    end else begin
      finished <= next_state == PASS || next_state == FAIL;
      success <= next_state == PASS;
      if (go) begin
        rcv_cnt <= '0;
        cmp_cnt <= '0;
        failIndex <= '0;
        failData <= '0;
      end else begin
        if (state == RUN && xfer && !surplus) rcv_cnt <= rcv_cnt + 1'b1;
        if (pop && !mismatch) cmp_cnt <= cmp_cnt + 1'b1;
        if (fail_entry) begin
          failIndex <= (!mismatch && surplus) ? NOUT_I : cmp_cnt;
          failData <= mismatch ? head : surplus ? outData : '0;
        end
      end
    end
  end
`ifdef OUT_CHANNEL_TIMEOUT_EN
  localparam int TW = clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TimeoutCycles - 1);
  logic [TW-1:0] idle_cnt;
  assign timeout = state == RUN && fifo_empty && !xfer && idle_cnt == TO_LAST;
  // idle counter runs only while running with nothing buffered or arriving
  always_ff @(posedge clock) begin
    if (!reset || go || xfer || state != RUN) idle_cnt <= '0;
    else if (fifo_empty) idle_cnt <= idle_cnt + 1'b1;
  end
  // timeout flag is captured with the failure record
  always_ff @(posedge clock) begin
    if (!reset || go) timedOut <= 1'b0;
    else if (fail_entry) timedOut <= timeout;
  end
`else
  assign timeout = 1'b0;
  assign timedOut = 1'b0;
`endif
endmodule
